fir_transposed: RTL and testbench
=================================

# fir_transposed

Parametrised N-tap transposed-form FIR filter in signed Q1.(DATA_WIDTH-1) fixed point. It replaces hand-chained single taps with one block that has a runtime coefficient-load sequencer, a sample valid handshake, optional rounding, and saturating arithmetic with a sticky overflow flag. It sits between the sample source and the downstream decimator/DAC path of the filter chain.

## Interface
- DATA_WIDTH, 24: sample, coefficient and output width (W), signed Q1.(W-1).
- NUM_TAPS, 8: number of taps N, ≥2.
- ROUND, 0: 1 = round-half-up when reducing products to W bits; 0 = truncate.
- SATURATE, 1: 1 = clamp products and sums to [-2^(W-1), 2^(W-1)-1]; 0 = two's-complement wrap.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_coef_load  in  1  start or restart a coefficient load sequence.
- i_coef_valid  in  1  iv_coef holds the next coefficient (LOADING only).
- iv_coef  in  W  coefficient, written in index order c0..c(N-1).
- o_loading  out  1  high in LOADING.
- i_valid  in  1  iv_din holds a sample.
- iv_din  in  W  input sample x[n].
- o_ready  out  1  high in RUN; a sample is accepted when i_valid & o_ready & !i_coef_load.
- o_valid  out  1  one-cycle pulse per accepted sample.
- ov_dout  out  W  filter output y[n], registered.
- o_sat  out  1  sticky: a saturation occurred (SATURATE=1 only).
- i_clr_sat  in  1  clears o_sat.

## Operation
- States: UNLOADED, LOADING, RUN. Reset enters UNLOADED.
- UNLOADED: o_ready=0. i_coef_load → LOADING.
- LOADING: o_loading=1. An index counter starts at 0. Each i_coef_valid writes coef[cnt] and increments cnt. The write at cnt=N-1 → RUN. i_coef_load while LOADING restarts at cnt=0; already-written coefficients stay until overwritten. i_valid is ignored.
- Entry to LOADING clears all partial-sum registers.
- RUN: o_ready=1. i_coef_load → LOADING and takes priority; a sample presented in the same cycle is dropped and produces no o_valid.
- Per accepted sample x:
  - p_k = reduce(c_k · x): the 2W-bit product bits [2W-2:W-1]. If ROUND=1, add 2^(W-2) before the slice.
  - The only product overflow is (-1)·(-1), which gives +1. It saturates to max when SATURATE=1 and wraps otherwise.
  - s_(N-1) ← p_(N-1).
  - s_k ← sat(p_k + s_(k+1)) for k = N-2..1.
  - ov_dout ← sat(p_0 + s_1).
  - Sums are computed at W+1 bits, then clamped (SATURATE=1) or the low W bits are kept (SATURATE=0).
- Partial sums advance only on accepted samples; idle cycles hold state.
- o_sat sets on any clamp during an accepted sample. i_clr_sat clears it; if set and clear occur in the same cycle, set wins.
- Coefficients are held until the next load or reset; there is no readback.

## Timing
- Reset values: o_valid=0, ov_dout=0, o_ready=0, o_loading=0, o_sat=0. All coefficients, partial sums and cnt are 0.
- Latency: o_valid and ov_dout appear on the edge after acceptance (1 cycle). Full throughput is one sample per clock.
- ov_dout holds its last value while o_valid=0.
- The RUN → LOADING transition occurs on the i_coef_load edge; o_ready is low from the next cycle.
- The LOADING → RUN transition occurs on the edge of the last coefficient write; samples are accepted from the next cycle.
- Asserting i_rst mid-load or mid-stream immediately forces the reset values; any in-flight o_valid is lost.

## Test plan
- Setup for all scenarios: W=8, N=4, ROUND=0, SATURATE=1.
- Impulse response: load 0x40,0x20,0x00,0x00. Send 0x7F then three 0x00 samples, back-to-back → ov_dout 0x3F, 0x1F, 0x00, 0x00, each with a single-cycle o_valid, 1 cycle after acceptance.
- Rounding: same stimulus with ROUND=1 → first output 0x40.
- Saturation: load four 0x7F coefficients. Send steady 0x7F → outputs 0x7E, then 0x7F (clamped), and o_sat=1. Pulse i_clr_sat → o_sat=0 and it re-sets on the next clamping sample. Rerun with SATURATE=0 → second output 0xFC.
- Product corner: coefficient 0x80 at c0, input 0x80 → output 0x7F and o_sat=1.
- Load/sample collision and reload: in RUN, assert i_coef_load together with i_valid → no o_valid, and o_loading=1 on the next cycle. After 2 coefficient writes, reassert i_coef_load → cnt restarts; 4 further writes are needed to reach RUN, and the old filter history does not leak into the output.
- Reset mid-load: assert i_rst after 2 of 4 coefficient writes → all outputs return to reset values immediately. Samples are ignored (o_ready=0) until a full reload completes.

Source files
------------

// File: rtl/fir_transposed.sv
// Transposed-form N-tap FIR in signed Q1.(W-1) with a runtime coefficient loader and a sticky saturation flag.
// Output is registered one cycle after acceptance at one sample per clock; o_ready stays low outside RUN.
module fir_transposed #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_TAPS   = 8,
  parameter int ROUND      = 0,
  parameter int SATURATE   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_coef_load,
  input  logic                  i_coef_valid,
  input  logic [DATA_WIDTH-1:0] iv_coef,
  output logic                  o_loading,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] iv_din,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] ov_dout,
  output logic                  o_sat,
  input  logic                  i_clr_sat
);
  localparam int W  = DATA_WIDTH;
  localparam int N  = NUM_TAPS;
  localparam int CW = $clog2(N);
  localparam logic signed [W-1:0]   MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]   MIN_V = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [2*W-1:0] RND_K = (ROUND != 0) ? ((2*W)'(1) << (W-2)) : (2*W)'(0);

  typedef enum logic [1:0] {ST_UNLOADED, ST_LOADING, ST_RUN} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt;
  logic signed [W-1:0]    coef      [N];
  logic signed [W-1:0]    psum      [1:N-1];
  logic signed [2*W-1:0]  prod_full [N];
  logic signed [W:0]      prod_top  [N];
  logic signed [W-1:0]    prod_red  [N];
  logic [N-1:0]           prod_clamp;
  logic signed [W:0]      sum_full  [N-1];
  logic signed [W-1:0]    sum_red   [N-1];
  logic [N-2:0]           sum_clamp;
  logic                   accept;
  logic                   last_write;

  assign accept     = (state == ST_RUN) && i_valid && !i_coef_load;
  assign last_write = (state == ST_LOADING) && !i_coef_load && i_coef_valid && (cnt == CW'(N-1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_UNLOADED;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_UNLOADED: if (i_coef_load) state_nxt = ST_LOADING;
      ST_LOADING:  if (last_write)  state_nxt = ST_RUN;
      ST_RUN:      if (i_coef_load) state_nxt = ST_LOADING;
      default:     state_nxt = ST_UNLOADED;
    endcase
  end

  always_comb begin
    o_ready   = (state == ST_RUN);
    o_loading = (state == ST_LOADING);
  end

  // Product reduction keeps bits [2W-2:W-1]; only (-1)*(-1) can leave the W-bit range.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      prod_full[k]  = (2*W)'(coef[k]) * (2*W)'($signed(iv_din)) + RND_K;
      prod_top[k]   = (W+1)'(prod_full[k] >>> (W-1));
      prod_red[k]   = prod_top[k][W-1:0];
      prod_clamp[k] = 1'b0;
      if ((SATURATE != 0) && (prod_top[k][W] != prod_top[k][W-1])) begin
        prod_clamp[k] = 1'b1;
        prod_red[k]   = prod_top[k][W] ? MIN_V : MAX_V;
      end
    end
  end

  // sum_red[0] is the next output; sum_red[k>0] becomes psum[k].
  always_comb begin
    for (int k = 0; k < N-1; k++) begin
      sum_full[k]  = (W+1)'(prod_red[k]) + (W+1)'(psum[k+1]);
      sum_red[k]   = sum_full[k][W-1:0];
      sum_clamp[k] = 1'b0;
      if ((SATURATE != 0) && (sum_full[k][W] != sum_full[k][W-1])) begin
        sum_clamp[k] = 1'b1;
        sum_red[k]   = sum_full[k][W] ? MIN_V : MAX_V;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
      for (int k = 0; k < N; k++) coef[k] <= '0;
    end else if (i_coef_load) begin
      cnt <= '0;
    end else if ((state == ST_LOADING) && i_coef_valid) begin
      coef[cnt] <= iv_coef;
      cnt       <= (cnt == CW'(N-1)) ? '0 : cnt + CW'(1);
    end
  end

  // Any load request wipes the filter history so a new coefficient set starts clean.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 1; k < N; k++) psum[k] <= '0;
    end else if (i_coef_load) begin
      for (int k = 1; k < N; k++) psum[k] <= '0;
    end else if (accept) begin
      psum[N-1] <= prod_red[N-1];
      for (int k = 1; k < N-1; k++) psum[k] <= sum_red[k];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      ov_dout <= '0;
      o_sat   <= 1'b0;
    end else begin
      o_valid <= accept;
      if (accept) ov_dout <= sum_red[0];
      if (accept && ((|prod_clamp) || (|sum_clamp))) o_sat <= 1'b1;
      else if (i_clr_sat)                            o_sat <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fir_transposed.sv
// Scoreboard bench: three DUT variants (trunc/sat, round/sat, trunc/wrap) share one stimulus stream
// and are checked against a sample-history reference model of the nested saturating FIR sum.
module tb_fir_transposed;
  localparam int N = 4;
  localparam int M_UNL = 0, M_LD = 1, M_RUN = 2;

  typedef struct {
    int         due;
    logic [7:0] dout;
    logic       sat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       coef_load, coef_valid, din_valid, clr_sat;
  logic [7:0] coef_in, din;
  logic [2:0] vld_o, rdy_o, ld_o, sat_o;
  logic [7:0] dout_o [3];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int   coef_m [N];
  int   hist   [N];
  int   mstate;
  int   mcnt;
  bit   msat [3];
  exp_t q0[$], q1[$], q2[$];
  int   log_d0[$], log_d1[$], log_d2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fir_transposed #(
      .DATA_WIDTH(8), .NUM_TAPS(N), .ROUND((g == 1) ? 1 : 0), .SATURATE((g == 2) ? 0 : 1)
    ) u_dut (
      .i_clk(clk), .i_rst(rst), .i_coef_load(coef_load), .i_coef_valid(coef_valid),
      .iv_coef(coef_in), .o_loading(ld_o[g]), .i_valid(din_valid), .iv_din(din),
      .o_ready(rdy_o[g]), .o_valid(vld_o[g]), .ov_dout(dout_o[g]), .o_sat(sat_o[g]),
      .i_clr_sat(clr_sat)
    );
  end

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Q1.7 product: floor((c*x [+64]) / 128); +1.0 is the only out-of-range result.
  function automatic int red_prod(int c, int x, bit rnd, bit sat, output bit clamp);
    int v;
    v = (c * x + (rnd ? 64 : 0)) >>> 7;
    clamp = 1'b0;
    if (v > 127) begin
      if (sat) begin clamp = 1'b1; v = 127; end
      else v -= 256;
    end
    return v;
  endfunction

  function automatic int add_sat(int a, int b, bit sat, output bit clamp);
    int v;
    v = a + b;
    clamp = 1'b0;
    if (v > 127) begin
      if (sat) begin clamp = 1'b1; v = 127; end
      else v -= 256;
    end else if (v < -128) begin
      if (sat) begin clamp = 1'b1; v = -128; end
      else v += 256;
    end
    return v;
  endfunction

  // Nested sum from tap k0 outward, tap k0 seeing sample hist[j0], older samples on higher taps.
  function automatic int tail(int k0, int j0, bit rnd, bit sat);
    bit cl;
    int acc, p;
    acc = red_prod(coef_m[N-1], hist[j0+N-1-k0], rnd, sat, cl);
    for (int k = N-2; k >= k0; k--) begin
      p   = red_prod(coef_m[k], hist[j0+k-k0], rnd, sat, cl);
      acc = add_sat(p, acc, sat, cl);
    end
    return acc;
  endfunction

  // Output for the newest sample; clamp_any covers every sum whose outermost term uses it.
  function automatic int eval_out(int i, output bit clamp_any);
    bit r, s, cl;
    int p, t, y;
    r = (i == 1);
    s = (i != 2);
    clamp_any = 1'b0;
    y = 0;
    for (int k = 0; k < N; k++) begin
      p = red_prod(coef_m[k], hist[0], r, s, cl);
      clamp_any |= cl;
      if (k < N-1) begin
        t = tail(k+1, 1, r, s);
        p = add_sat(p, t, s, cl);
        clamp_any |= cl;
      end
      if (k == 0) y = p;
    end
    return y;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin coef_m[k] = 0; hist[k] = 0; end
    mstate = M_UNL;
    mcnt   = 0;
    for (int i = 0; i < 3; i++) msat[i] = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
  endtask

  task automatic model_step(bit load, bit cv, logic [7:0] c, bit v, logic [7:0] x, bit clr);
    bit   acc, cl;
    int   y;
    exp_t e;
    acc = 1'b0;
    if (load) begin
      mstate = M_LD;
      mcnt   = 0;
      for (int k = 0; k < N; k++) hist[k] = 0;
    end else if (mstate == M_LD && cv) begin
      coef_m[mcnt] = int'($signed(c));
      if (mcnt == N-1) mstate = M_RUN;
      mcnt = (mcnt + 1) % N;
    end else if (mstate == M_RUN && v) begin
      acc = 1'b1;
      for (int k = N-1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = int'($signed(x));
    end
    for (int i = 0; i < 3; i++) begin
      cl = 1'b0;
      y  = 0;
      if (acc) y = eval_out(i, cl);
      if (acc && cl) msat[i] = 1'b1;
      else if (clr)  msat[i] = 1'b0;
      if (acc) begin
        e.due  = cyc + 1;
        e.dout = y[7:0];
        e.sat  = msat[i];
        case (i)
          0:       q0.push_back(e);
          1:       q1.push_back(e);
          default: q2.push_back(e);
        endcase
      end
    end
  endtask

  task automatic step(bit load, bit cv, logic [7:0] c, bit v, logic [7:0] x, bit clr);
    coef_load  = load;
    coef_valid = cv;
    coef_in    = c;
    din_valid  = v;
    din        = x;
    clr_sat    = clr;
    model_step(load, cv, c, v, x, clr);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("o_ready[%0d]", i), int'(rdy_o[i]), int'(mstate == M_RUN));
      chk($sformatf("o_loading[%0d]", i), int'(ld_o[i]), int'(mstate == M_LD));
    end
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(0, 0, 8'h00, 0, 8'h00, 0);
  endtask

  task automatic send(logic [7:0] x);
    step(0, 0, 8'h00, 1, x, 0);
  endtask

  task automatic load4(logic [7:0] c0, logic [7:0] c1, logic [7:0] c2, logic [7:0] c3);
    step(1, 0, 8'h00, 0, 8'h00, 0);
    step(0, 1, c0, 0, 8'h00, 0);
    step(0, 1, c1, 0, 8'h00, 0);
    step(0, 1, c2, 0, 8'h00, 0);
    step(0, 1, c3, 0, 8'h00, 0);
  endtask

  task automatic check_reset_outputs(string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s o_valid[%0d]", tag, i), int'(vld_o[i]), 0);
      chk($sformatf("%s ov_dout[%0d]", tag, i), int'(dout_o[i]), 0);
      chk($sformatf("%s o_ready[%0d]", tag, i), int'(rdy_o[i]), 0);
      chk($sformatf("%s o_loading[%0d]", tag, i), int'(ld_o[i]), 0);
      chk($sformatf("%s o_sat[%0d]", tag, i), int'(sat_o[i]), 0);
    end
  endtask

  function automatic int logv(int i, int j);
    case (i)
      0:       return (j < log_d0.size()) ? log_d0[j] : -1;
      1:       return (j < log_d1.size()) ? log_d1[j] : -1;
      default: return (j < log_d2.size()) ? log_d2[j] : -1;
    endcase
  endfunction

  task automatic clear_logs();
    log_d0.delete(); log_d1.delete(); log_d2.delete();
  endtask

  function automatic logic [7:0] pick8();
    logic [7:0] corners [4];
    corners = '{8'h7F, 8'h80, 8'h81, 8'h01};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic check_out(int i);
    exp_t e;
    bit   empty;
    case (i)
      0:       empty = (q0.size() == 0);
      1:       empty = (q1.size() == 0);
      default: empty = (q2.size() == 0);
    endcase
    if (empty) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected o_valid[%0d]: got 1 expected 0 at cycle %0d (dout 0x%0h)", i, cyc, dout_o[i]);
    end else begin
      case (i)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("latency[%0d]", i), cyc, e.due);
      chk($sformatf("ov_dout[%0d]", i), int'(dout_o[i]), int'(e.dout));
      chk($sformatf("o_sat[%0d]", i), int'(sat_o[i]), int'(e.sat));
    end
    case (i)
      0:       log_d0.push_back(int'(dout_o[0]));
      1:       log_d1.push_back(int'(dout_o[1]));
      default: log_d2.push_back(int'(dout_o[2]));
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (vld_o[i] === 1'b1) check_out(i);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    coef_load = 0; coef_valid = 0; coef_in = 0; din_valid = 0; din = 0; clr_sat = 0;
    model_reset();
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Impulse response, truncate and round variants.
    clear_logs();
    load4(8'h40, 8'h20, 8'h00, 8'h00);
    send(8'h7F); send(8'h00); send(8'h00); send(8'h00);
    idle(1);
    chk("impulse y0", logv(0, 0), 'h3F);
    chk("impulse y1", logv(0, 1), 'h1F);
    chk("impulse y2", logv(0, 2), 'h00);
    chk("impulse y3", logv(0, 3), 'h00);
    chk("impulse round y0", logv(1, 0), 'h40);

    // Saturation, clear, and re-set on the next clamp.
    clear_logs();
    load4(8'h7F, 8'h7F, 8'h7F, 8'h7F);
    send(8'h7F); send(8'h7F);
    idle(1);
    chk("sat y0", logv(0, 0), 'h7E);
    chk("sat y1", logv(0, 1), 'h7F);
    chk("sat flag", int'(sat_o[0]), 1);
    chk("wrap y1", logv(2, 1), 'hFC);
    chk("wrap flag", int'(sat_o[2]), 0);
    step(0, 0, 8'h00, 0, 8'h00, 1);
    chk("sat cleared", int'(sat_o[0]), 0);
    send(8'h7F);
    chk("sat re-set", int'(sat_o[0]), 1);
    idle(1);

    // (-1)*(-1) product corner.
    clear_logs();
    load4(8'h80, 8'h00, 8'h00, 8'h00);
    step(0, 0, 8'h00, 0, 8'h00, 1);
    send(8'h80);
    idle(1);
    chk("corner y0", logv(0, 0), 'h7F);
    chk("corner flag", int'(sat_o[0]), 1);

    // Load/sample collision, partial reload restart, no history leak.
    load4(8'h40, 8'h40, 8'h40, 8'h40);
    send(8'h60); send(8'h60);
    idle(1);
    clear_logs();
    step(1, 0, 8'h00, 1, 8'h55, 0);
    chk("collision loading", int'(ld_o[0]), 1);
    step(0, 1, 8'h10, 0, 8'h00, 0);
    step(0, 1, 8'h20, 0, 8'h00, 0);
    load4(8'h40, 8'h00, 8'h00, 8'h00);
    send(8'h7F);
    idle(1);
    chk("reload y0", logv(0, 0), 'h3F);

    // Reset in the middle of a load.
    step(1, 0, 8'h00, 0, 8'h00, 0);
    step(0, 1, 8'h11, 0, 8'h00, 0);
    step(0, 1, 8'h22, 0, 8'h00, 0);
    rst = 1'b1;
    #1;
    check_reset_outputs("midload reset");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h7F); send(8'h40);
    step(0, 1, 8'h33, 1, 8'h12, 0);
    load4(8'h20, 8'hE0, 8'h10, 8'h7F);
    send(8'h50); send(8'hB0);
    idle(1);

    // Randomised traffic: sparse reloads, gapped coefficient writes, set/clear races.
    for (int it = 0; it < 1500; it++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 1) == 1), pick8(),
           ($urandom_range(0, 3) != 0), pick8(), ($urandom_range(0, 15) == 0));
    end
    idle(3);
    chk("queue0 drained", q0.size(), 0);
    chk("queue1 drained", q1.size(), 0);
    chk("queue2 drained", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
